// File: rtl/intr_control.sv
`default_nettype none
// ============================================================================
// Module      : intr_control
// Description : Interrupt and bus-request scheduler for the CPU control unit.
//               It latches NMI edges and samples INT and BUSRQ at the
//               instruction boundaries that the sequencer signals. It
//               arbitrates BUSRQ > NMI > INT and drives the acknowledge and
//               grant handshake. It also owns IFF1/IFF2 and the interrupt
//               mode register.
// Ports       : clk_i, reset_i (async, active-high)
//               nmi_i (edge), intr_i (level), busrq_i
//               sample_i   - instruction-boundary strobe
//               halted_i   - CPU is in HALT
//               ack_done_i - sequencer finished the acknowledge cycle
//               ei_i/di_i/retn_i/im_wr_i/im_val_i - instruction side effects
//               take_nmi_o/take_int_o/busack_o - handshake outputs
//               exit_halt_o - one-cycle pulse when an accepted NMI/INT
//                             leaves HALT
//               iff1_o/iff2_o/int_mode_o - architectural interrupt state
// Revision    : 1.0 - initial release
// ============================================================================
module intr_control #(
    parameter int unsigned EI_DELAY = 1
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       nmi_i,
    input  logic       intr_i,
    input  logic       busrq_i,
    input  logic       sample_i,
    input  logic       halted_i,
    input  logic       ack_done_i,
    input  logic       ei_i,
    input  logic       di_i,
    input  logic       retn_i,
    input  logic       im_wr_i,
    input  logic [1:0] im_val_i,
    output logic       take_nmi_o,
    output logic       take_int_o,
    output logic       busack_o,
    output logic       exit_halt_o,
    output logic       iff1_o,
    output logic       iff2_o,
    output logic [1:0] int_mode_o
);

    localparam int unsigned      BLK_W    = (EI_DELAY < 2) ? 1 : $clog2(EI_DELAY + 1);
    localparam logic [BLK_W-1:0] BLK_INIT = BLK_W'(EI_DELAY);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_GRANT   = 2'd1;
    localparam logic [1:0] ST_NMI_ACK = 2'd2;
    localparam logic [1:0] ST_INT_ACK = 2'd3;

    logic [1:0]       state_q, state_d;
    logic             nmi_prev_q;
    logic             nmi_pend_q, nmi_pend_d;
    logic             iff1_q, iff1_d;
    logic             iff2_q, iff2_d;
    logic [1:0]       mode_q, mode_d;
    logic [BLK_W-1:0] blk_q, blk_d;
    logic             exit_halt_q, exit_halt_d;

    logic nmi_edge_w;
    logic int_ok_w;
    logic nmi_acc_w;
    logic int_acc_w;
    logic ei_take_w;

    assign nmi_edge_w = nmi_i & ~nmi_prev_q;
    assign int_ok_w   = intr_i & iff1_q & (blk_q == '0);

    // Arbitration and state transitions
    always_comb begin
        state_d   = state_q;
        nmi_acc_w = 1'b0;
        int_acc_w = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (sample_i) begin
                    if (busrq_i) begin
                        state_d = ST_GRANT;
                    end else if (nmi_pend_q) begin
                        state_d   = ST_NMI_ACK;
                        nmi_acc_w = 1'b1;
                    end else if (int_ok_w) begin
                        state_d   = ST_INT_ACK;
                        int_acc_w = 1'b1;
                    end
                end
            end
            ST_GRANT: begin
                if (!busrq_i) state_d = ST_IDLE;
            end
            ST_NMI_ACK, ST_INT_ACK: begin
                if (ack_done_i) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ei only counts when nothing of higher priority touches the IFFs this cycle
    assign ei_take_w = ei_i & ~di_i & ~nmi_acc_w & ~int_acc_w;

    always_comb begin
        // A fresh edge in the accept cycle re-arms the latch so it is not lost
        nmi_pend_d = (nmi_pend_q & ~nmi_acc_w) | nmi_edge_w;

        iff1_d = iff1_q;
        iff2_d = iff2_q;
        if (nmi_acc_w) begin
            iff2_d = iff1_q;
            iff1_d = 1'b0;
        end else if (int_acc_w || di_i) begin
            iff1_d = 1'b0;
            iff2_d = 1'b0;
        end else if (ei_i) begin
            iff1_d = 1'b1;
            iff2_d = 1'b1;
        end else if (retn_i) begin
            iff1_d = iff2_q;
        end

        blk_d = blk_q;
        if (ei_take_w) begin
            blk_d = BLK_INIT;
        end else if (sample_i && (blk_q != '0)) begin
            blk_d = blk_q - BLK_W'(1);
        end

        mode_d = mode_q;
        if (im_wr_i) begin
            mode_d = (im_val_i == 2'd3) ? 2'd2 : im_val_i;
        end

        exit_halt_d = (nmi_acc_w | int_acc_w) & halted_i;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= ST_IDLE;
            // Treat nmi as already high so a level held across reset is not an edge
            nmi_prev_q  <= 1'b1;
            nmi_pend_q  <= 1'b0;
            iff1_q      <= 1'b0;
            iff2_q      <= 1'b0;
            mode_q      <= 2'd0;
            blk_q       <= '0;
            exit_halt_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            nmi_prev_q  <= nmi_i;
            nmi_pend_q  <= nmi_pend_d;
            iff1_q      <= iff1_d;
            iff2_q      <= iff2_d;
            mode_q      <= mode_d;
            blk_q       <= blk_d;
            exit_halt_q <= exit_halt_d;
        end
    end

    assign take_nmi_o  = (state_q == ST_NMI_ACK);
    assign take_int_o  = (state_q == ST_INT_ACK);
    assign busack_o    = (state_q == ST_GRANT);
    assign exit_halt_o = exit_halt_q;
    assign iff1_o      = iff1_q;
    assign iff2_o      = iff2_q;
    assign int_mode_o  = mode_q;

endmodule
`default_nettype wire

// File: tb/tb_intr_control.sv
`default_nettype none
// ============================================================================
// Module      : tb_intr_control
// Description : Self-checking bench for intr_control. A directed table walks
//               the main scenarios. A hand sequence covers the asynchronous
//               reset during an acknowledge. A random phase is compared
//               against a rule-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_intr_control;

    localparam int EI_DELAY = 1;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       nmi = 1'b0, intr = 1'b0, busrq = 1'b0, sample = 1'b0, halted = 1'b0;
    logic       ack_done = 1'b0, ei = 1'b0, di = 1'b0, retn = 1'b0, im_wr = 1'b0;
    logic [1:0] im_val = 2'd0;
    logic       take_nmi, take_int, busack, exit_halt, iff1, iff2;
    logic [1:0] int_mode;

    int n_vec = 0;
    int n_bad = 0;

    intr_control #(.EI_DELAY(EI_DELAY)) dut (
        .clk_i      (clk),
        .reset_i    (reset),
        .nmi_i      (nmi),
        .intr_i     (intr),
        .busrq_i    (busrq),
        .sample_i   (sample),
        .halted_i   (halted),
        .ack_done_i (ack_done),
        .ei_i       (ei),
        .di_i       (di),
        .retn_i     (retn),
        .im_wr_i    (im_wr),
        .im_val_i   (im_val),
        .take_nmi_o (take_nmi),
        .take_int_o (take_int),
        .busack_o   (busack),
        .exit_halt_o(exit_halt),
        .iff1_o     (iff1),
        .iff2_o     (iff2),
        .int_mode_o (int_mode)
    );

    always #5 clk = ~clk;

    // ---------------- reference model (rule level) ----------------
    localparam int S_IDLE = 0, S_GRANT = 1, S_NMI = 2, S_INT = 3;
    int m_state, m_block, m_mode;
    bit m_pend, m_prev, m_iff1, m_iff2, m_exit;

    task automatic model_update();
        bit edge_seen, acc_nmi, acc_int;
        int nstate;
        if (reset) begin
            m_state = S_IDLE; m_block = 0; m_mode = 0;
            m_pend = 0; m_prev = 1; m_iff1 = 0; m_iff2 = 0; m_exit = 0;
            return;
        end
        edge_seen = nmi && !m_prev;
        m_prev    = nmi;
        acc_nmi = 0; acc_int = 0; nstate = m_state;
        if (m_state == S_IDLE && sample) begin
            if (busrq) nstate = S_GRANT;
            else if (m_pend) begin nstate = S_NMI; acc_nmi = 1; end
            else if (intr && m_iff1 && m_block == 0) begin nstate = S_INT; acc_int = 1; end
        end else if (m_state == S_GRANT && !busrq) begin
            nstate = S_IDLE;
        end else if ((m_state == S_NMI || m_state == S_INT) && ack_done) begin
            nstate = S_IDLE;
        end
        if (acc_nmi) m_pend = 0;
        if (edge_seen) m_pend = 1;
        m_exit = (acc_nmi || acc_int) && halted;
        if (acc_nmi) begin
            m_iff2 = m_iff1; m_iff1 = 0;
            if (sample && m_block > 0) m_block--;
        end else if (acc_int || di) begin
            m_iff1 = 0; m_iff2 = 0;
            if (sample && m_block > 0) m_block--;
        end else if (ei) begin
            m_iff1 = 1; m_iff2 = 1; m_block = EI_DELAY;
        end else begin
            if (retn) m_iff1 = m_iff2;
            if (sample && m_block > 0) m_block--;
        end
        if (im_wr) m_mode = (im_val == 2'd3) ? 2 : int'(im_val);
        m_state = nstate;
    endtask

    function automatic logic [7:0] model_out();
        logic [1:0] md;
        md = 2'(m_mode);
        return {m_state == S_NMI, m_state == S_INT, m_state == S_GRANT,
                m_exit, m_iff1, m_iff2, md};
    endfunction

    function automatic logic [7:0] dut_out();
        return {take_nmi, take_int, busack, exit_halt, iff1, iff2, int_mode};
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b want %b (tn,ti,ba,eh,i1,i2,mode)", name, act, exp);
        end
    endtask

    // Advance one clock; the model sees the same inputs the DUT sampled.
    task automatic step();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    // inputs: {nmi,intr,busrq,sample,halted,ack,ei,di,retn,im_wr,im_val[1:0]}
    task automatic apply(input logic [11:0] v);
        {nmi, intr, busrq, sample, halted, ack_done, ei, di, retn, im_wr, im_val} = v;
    endtask

    typedef struct {
        logic [11:0] in;
        logic [7:0]  exp;   // {tn,ti,ba,eh,i1,i2,mode}
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic [11:0] in, input logic [7:0] exp);
        vec_t v;
        v.in = in; v.exp = exp;
        tbl.push_back(v);
    endtask

    initial begin
        // NMI held through reset is not an edge; then a real 0->1 edge
        for (int i = 0; i < 5; i++) add(12'b1_0_0_1_0_0_0_0_0_0_00, 8'b0_0_0_0_0_0_00);
        add(12'b0_0_0_0_0_0_0_0_0_0_00, 8'b0_0_0_0_0_0_00);
        add(12'b1_0_0_0_0_0_0_0_0_0_00, 8'b0_0_0_0_0_0_00);
        add(12'b1_0_0_1_0_0_0_0_0_0_00, 8'b1_0_0_0_0_0_00);
        add(12'b1_0_0_0_0_0_0_0_0_0_00, 8'b1_0_0_0_0_0_00);
        add(12'b0_0_0_0_0_1_0_0_0_0_00, 8'b0_0_0_0_0_0_00);
        // EI blocks INT for one sample
        add(12'b0_0_0_0_0_0_1_0_0_0_00, 8'b0_0_0_0_1_1_00);
        add(12'b0_1_0_1_0_0_0_0_0_0_00, 8'b0_0_0_0_1_1_00);
        add(12'b0_1_0_1_0_0_0_0_0_0_00, 8'b0_1_0_0_0_0_00);
        add(12'b0_1_0_0_0_0_0_0_0_0_00, 8'b0_1_0_0_0_0_00);
        add(12'b0_0_0_0_0_1_0_0_0_0_00, 8'b0_0_0_0_0_0_00);
        // IFF behaviour on NMI accept, RETN, EI+DI
        add(12'b0_0_0_0_0_0_1_0_0_0_00, 8'b0_0_0_0_1_1_00);
        add(12'b1_0_0_0_0_0_0_0_0_0_00, 8'b0_0_0_0_1_1_00);
        add(12'b1_0_0_1_0_0_0_0_0_0_00, 8'b1_0_0_0_0_1_00);
        add(12'b0_0_0_0_0_1_0_0_0_0_00, 8'b0_0_0_0_0_1_00);
        add(12'b0_0_0_0_0_0_0_0_1_0_00, 8'b0_0_0_0_1_1_00);
        add(12'b0_0_0_0_0_0_1_1_0_0_00, 8'b0_0_0_0_0_0_00);
        // BUSRQ beats a pending NMI; NMI served after the grant
        add(12'b0_0_0_0_0_0_0_0_0_0_00, 8'b0_0_0_0_0_0_00);
        add(12'b1_0_0_0_0_0_0_0_0_0_00, 8'b0_0_0_0_0_0_00);
        add(12'b1_0_1_1_0_0_0_0_0_0_00, 8'b0_0_1_0_0_0_00);
        add(12'b0_0_1_1_0_0_0_0_0_0_00, 8'b0_0_1_0_0_0_00);
        add(12'b0_0_0_0_0_0_0_0_0_0_00, 8'b0_0_0_0_0_0_00);
        add(12'b0_0_0_1_0_0_0_0_0_0_00, 8'b1_0_0_0_0_0_00);
        add(12'b0_0_0_0_0_1_0_0_0_0_00, 8'b0_0_0_0_0_0_00);
        // INT out of HALT: exit_halt is a single-cycle pulse
        add(12'b0_0_0_0_0_0_1_0_0_0_00, 8'b0_0_0_0_1_1_00);
        add(12'b0_0_0_1_0_0_0_0_0_0_00, 8'b0_0_0_0_1_1_00);
        add(12'b0_1_0_1_1_0_0_0_0_0_00, 8'b0_1_0_1_0_0_00);
        add(12'b0_1_0_0_1_0_0_0_0_0_00, 8'b0_1_0_0_0_0_00);
        add(12'b0_0_0_0_1_1_0_0_0_0_00, 8'b0_0_0_0_0_0_00);
        // Interrupt mode writes (3 maps to 2); ack_done while idle is ignored
        add(12'b0_0_0_0_0_0_0_0_0_1_11, 8'b0_0_0_0_0_0_10);
        add(12'b0_0_0_0_0_0_0_0_0_1_01, 8'b0_0_0_0_0_0_01);
        add(12'b0_0_0_0_0_1_0_0_0_0_00, 8'b0_0_0_0_0_0_01);

        // ---- reset with nmi held high ----
        reset = 1'b1; nmi = 1'b1;
        repeat (3) step();
        check("reset_state", dut_out(), 8'h00);
        reset = 1'b0;

        // ---- directed table ----
        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i].in);
            step();
            check($sformatf("table[%0d]", i), dut_out(), tbl[i].exp);
        end

        // ---- asynchronous reset in the middle of INT_ACK ----
        apply(12'b0_0_0_0_0_0_1_0_0_0_00); step();
        apply(12'b0_0_0_1_0_0_0_0_0_0_00); step();
        apply(12'b0_1_0_1_0_0_0_0_0_0_00); step();
        apply(12'b0_1_0_0_0_0_0_0_0_0_00);
        check("int_ack_before_reset", dut_out(), 8'b0_1_0_0_0_0_01);
        #2 reset = 1'b1;
        #1 check("async_reset_mid_ack", dut_out(), 8'h00);
        step();

        // ---- randomized run against the reference model ----
        for (int i = 0; i < 3000; i++) begin
            reset    = ($urandom_range(0, 299) == 0) || (i < 2);
            if ($urandom_range(0, 3) == 0) nmi = ~nmi;
            intr     = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 5) == 0) busrq = ~busrq;
            sample   = ($urandom_range(0, 2) == 0);
            halted   = ($urandom_range(0, 3) == 0);
            ack_done = ($urandom_range(0, 3) == 0);
            ei       = ($urandom_range(0, 6) == 0);
            di       = ($urandom_range(0, 9) == 0);
            retn     = ($urandom_range(0, 9) == 0);
            im_wr    = ($urandom_range(0, 9) == 0);
            im_val   = 2'($urandom_range(0, 3));
            step();
            check($sformatf("random[%0d]", i), dut_out(), model_out());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/intr_control.md
Name: intr_control

Overview:
- Interrupt and bus-request scheduler for the CPU control unit.
- Latches NMI edges and samples INT and BUSRQ at instruction boundaries, as signalled by the sequencer.
- Arbitrates between BUSRQ, NMI and INT, and drives the acknowledge/grant handshake toward the sequencer and bus interface.
- Owns the IFF1/IFF2 flip-flops and the interrupt mode register.

Parameters:
- EI_DELAY, 1, number of instruction-boundary samples after EI during which INT is blocked (0 disables the blocking).

Ports:
- clk  input  1  CPU clock
- reset  input  1  asynchronous, active-high reset
- nmi  input  1  NMI request, already synchronized, active-high; edge-triggered
- intr  input  1  INT request, already synchronized, active-high; level
- busrq  input  1  bus request, synchronized, active-high
- sample  input  1  one-cycle strobe at the last T-state of an instruction
- halted  input  1  CPU is in HALT state
- ack_done  input  1  one-cycle strobe: sequencer finished the current acknowledge cycle
- ei  input  1  EI executed (one-cycle strobe)
- di  input  1  DI executed (one-cycle strobe)
- retn  input  1  RETN executed (one-cycle strobe)
- im_wr  input  1  IM instruction strobe
- im_val  input  2  new interrupt mode (0,1,2; value 3 treated as 2)
- take_nmi  output  1  NMI acknowledge in progress
- take_int  output  1  INT acknowledge in progress
- busack  output  1  bus granted
- exit_halt  output  1  one-cycle pulse: an accepted NMI/INT leaves HALT
- iff1  output  1  interrupt enable flip-flop 1
- iff2  output  1  interrupt enable flip-flop 2
- int_mode  output  2  current interrupt mode

Behaviour:
- All outputs and state registers are updated on the rising edge of clk.
- Reset (asynchronous, any time, including mid-acknowledge or mid-grant):
  - state=IDLE; nmi_pend=0; ei_block=0.
  - iff1=iff2=0; int_mode=0.
  - take_nmi=take_int=busack=exit_halt=0.
  - First NMI edge detection after reset release requires nmi to go 0->1; nmi held high through reset is not an edge.
- NMI latch:
  - nmi_pend sets on a rising edge of nmi in any state.
  - It clears only on the IDLE->NMI_ACK transition.
  - An edge arriving in the same cycle as that transition re-sets it, so the edge is not lost.
- IFF rules, in priority order per cycle:
  1. NMI accept: iff2<=iff1, iff1<=0.
  2. INT accept: iff1=iff2<=0.
  3. di: iff1=iff2<=0. If di and ei are both asserted, di wins.
  4. ei: iff1=iff2<=1, and ei_block<=EI_DELAY.
  5. retn: iff1<=iff2.
- ei_block decrements on each sample while nonzero and blocks INT while nonzero. It is never decremented below 0.
- im_wr: int_mode<=im_val (3 maps to 2). Takes effect the next cycle.
- States: IDLE, GRANT, NMI_ACK, INT_ACK.
- IDLE: requests are evaluated only when sample=1, with priority busrq > nmi_pend > (intr & iff1 & ei_block==0).
  - busrq -> GRANT; busack=1 from the next cycle.
  - nmi_pend -> NMI_ACK; take_nmi=1 from the next cycle.
  - INT condition -> INT_ACK; take_int=1 from the next cycle.
  - exit_halt pulses for one cycle on the NMI/INT transition when halted=1.
  - Nothing pending -> remain in IDLE.
- GRANT:
  - busack=1 while busrq=1.
  - When busrq=0, go to IDLE; busack=0 the next cycle.
  - NMI edges are still latched; INT is ignored.
  - The first IDLE sample after the grant ends re-evaluates requests.
- NMI_ACK / INT_ACK:
  - take_* held until ack_done; on ack_done go to IDLE and deassert take_* the next cycle.
  - sample and busrq are ignored; a busrq arriving here is served at the next sample after returning to IDLE.
- ack_done outside an ACK state has no effect.
- int_mode is output only; mode-specific vector handling belongs to the sequencer.

Test Plan:
- Reset release with nmi=1 held → no NMI_ACK after 5 samples; nmi 1->0->1 then sample → take_nmi=1 next cycle; ack_done → take_nmi=0 next cycle.
- ei, then intr=1 with sample on the next cycle → take_int stays 0. Second sample → take_int=1, iff1=iff2=0.
- busrq=1 and nmi edge both pending at sample → busack=1 and take_nmi=0. Drop busrq → busack=0, then next sample → take_nmi=1.
- iff1=iff2=1, accept NMI → iff1=0, iff2=1. retn → iff1=1. ei and di in the same cycle → iff1=iff2=0.
- halted=1, iff1=1, intr=1, sample → exit_halt high for exactly 1 cycle, take_int=1.
- Assert reset mid INT_ACK → take_int=0, int_mode=0, iff1=iff2=0 immediately (asynchronous). im_wr with im_val=3 → int_mode=2.
